instr_feeder: RTL and testbench
===============================

INSTR_FEEDER -- requirements
Module: instr_feeder

Interface
REQ-001 Parameter ADDR_W, default 5, program-memory address width (depth 2^ADDR_W words).
REQ-002 Parameter TIMEOUT, default 15, maximum cycles to wait for Done per instruction.
REQ-003 clk  input  1  single clock, all state updates on rising edge.
REQ-004 Reset  input  1  asynchronous, active-high reset.
REQ-005 Start  input  1  one-cycle request to run the stored program from address 0.
REQ-006 Done  input  1  processor instruction-complete indication.
REQ-007 prog_we  input  1  program-memory write enable.
REQ-008 prog_addr  input  ADDR_W  program-memory write address.
REQ-009 prog_wdata  input  16  program-memory write data.
REQ-010 Run  output  1  registered instruction-start strobe to the processor.
REQ-011 Din  output  16  registered instruction/immediate word to the processor.
REQ-012 Busy  output  1  high from Start acceptance until FINISH or ERROR.
REQ-013 Finished  output  1  sticky, program ended normally.
REQ-014 Timeout  output  1  sticky, Done not received within TIMEOUT cycles.
REQ-015 pc  output  ADDR_W  address of the instruction currently issued.

Function
REQ-016 Instruction word format SHALL be Din[8:6] opcode, [5:3] X, [2:0] Y; opcodes 000 mv, 001 mvi, 010 add, 011 sub, 111 halt; 100-110 SHALL be issued as ordinary single-word instructions.
REQ-017 States SHALL be IDLE, LOAD, ISSUE, WAIT, NEXT, FINISH, ERROR.
REQ-018 IDLE: Start=1 -> LOAD, pc<=0, Finished<=0, Timeout<=0, Busy<=1; Start is ignored in every other state except FINISH and ERROR, where it behaves as in IDLE.
REQ-019 LOAD (1 cycle): Din<=mem[pc]; if mem[pc][8:6]=111 -> FINISH without asserting Run, else -> ISSUE.
REQ-020 ISSUE (1 cycle): Run=1, Din holds instruction word; -> WAIT.
REQ-021 WAIT entry: if opcode is mvi, Din<=mem[(pc+1) mod 2^ADDR_W] in the first WAIT cycle, else Din holds; Run=0 throughout WAIT.
REQ-022 Done is sampled only in WAIT; Done in any other state is ignored.
REQ-023 WAIT: Done=1 -> NEXT; wait counter increments each WAIT cycle without Done; counter reaching TIMEOUT -> ERROR, Timeout<=1.
REQ-024 NEXT (1 cycle): pc advances by 2 for mvi, else by 1, modulo 2^ADDR_W; if the advance wraps past the last address -> FINISH, else -> LOAD.
REQ-025 mvi at last address SHALL take its immediate from address 0 and then end in FINISH.
REQ-026 FINISH: Finished=1, Busy=0, Run=0; ERROR: Timeout=1, Busy=0, Run=0; both hold until Start or Reset.
REQ-027 prog_we SHALL write mem[prog_addr] only when Busy=0; writes while Busy=1 are dropped.
REQ-028 Instruction issue latency: Start at cycle n -> Run=1 at cycle n+2 (IDLE->LOAD->ISSUE); Done-to-next-Run SHALL be 3 cycles.

Reset
REQ-029 Reset=1 SHALL immediately force IDLE, Run=0, Din=0, Busy=0, Finished=0, Timeout=0, pc=0, wait counter=0, including mid-instruction.
REQ-030 Program-memory contents SHALL NOT be affected by Reset.

Structure
REQ-031 Opcode constants, state encoding and the 16-bit word width SHALL live in the shared processor package.
REQ-032 Program memory SHALL be a sub-module prog_ram (synchronous write, combinational read, no reset).

Verification
REQ-033 Load {mvi R0 / 0x0005, mvi R1 / 0x0003, add R0,R1, halt}, Start, Done 2 cycles after each Run -> Din sequence 0x0040,0x0005,0x0048,0x0003,0x0081; three Run pulses; Finished=1.
REQ-034 Done never asserted after first Run -> Timeout=1 after exactly 15 WAIT cycles, Busy=0, no further Run.
REQ-035 Full memory of mv words without halt -> 32 Run pulses, pc 0..31, then Finished=1.
REQ-036 mvi at address 31, address 0 = 0x1234 -> Din=0x1234 in the first WAIT cycle, then Finished=1.
REQ-037 Reset asserted in WAIT -> Run/Busy/Din=0 same cycle; Start afterwards re-runs from pc=0 with memory intact.
REQ-038 prog_we while Busy=1 -> memory unchanged; Start while Busy=1 -> ignored, pc sequence undisturbed.

Source files
------------

// File: rtl/instr_feeder_pkg.sv
// -----------------------------------------------------------------------------
// instr_feeder_pkg
//   Shared processor definitions used by the instruction feeder and its
//   program memory: instruction word width, opcode field position, opcode
//   constants and the feeder state encoding.
// -----------------------------------------------------------------------------
package instr_feeder_pkg;

  // Width of an instruction / immediate word.
  localparam int WORD_W = 16;

  // Opcode field position inside an instruction word: [8:6] opcode,
  // [5:3] X register, [2:0] Y register.
  localparam int OPC_HI = 8;
  localparam int OPC_LO = 6;

  typedef logic [2:0] opcode_t;

  localparam opcode_t OP_MV   = 3'b000;
  localparam opcode_t OP_MVI  = 3'b001;
  localparam opcode_t OP_ADD  = 3'b010;
  localparam opcode_t OP_SUB  = 3'b011;
  localparam opcode_t OP_HALT = 3'b111;

  // Feeder sequencing states.
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_ISSUE  = 3'd2,
    ST_WAIT   = 3'd3,
    ST_NEXT   = 3'd4,
    ST_FINISH = 3'd5,
    ST_ERROR  = 3'd6
  } state_t;

  // mvi is the only two-word instruction: its immediate follows it.
  function automatic logic is_mvi(input opcode_t op);
    return (op == OP_MVI);
  endfunction

  // halt ends the program and is never issued to the processor.
  function automatic logic is_halt(input opcode_t op);
    return (op == OP_HALT);
  endfunction

endpackage

// File: rtl/instr_feeder_prog_ram.sv
// -----------------------------------------------------------------------------
// prog_ram
//   Program memory for the instruction feeder. Synchronous write, two
//   combinational read ports (instruction word and the word after it, used as
//   the mvi immediate). Contents are not reset.
//
// Ports
//   clk        : clock, write on rising edge
//   i_we       : write enable (already qualified by the caller)
//   i_waddr    : write address
//   i_wdata    : write data
//   i_raddr_a  : read address, port A
//   o_rdata_a  : read data, port A (combinational)
//   i_raddr_b  : read address, port B
//   o_rdata_b  : read data, port B (combinational)
// -----------------------------------------------------------------------------
module prog_ram
  import instr_feeder_pkg::*;
#(
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [WORD_W-1:0] i_wdata,
  input  logic [ADDR_W-1:0] i_raddr_a,
  output logic [WORD_W-1:0] o_rdata_a,
  input  logic [ADDR_W-1:0] i_raddr_b,
  output logic [WORD_W-1:0] o_rdata_b
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [WORD_W-1:0] r_mem [DEPTH];

  always_ff @(posedge clk) begin
    if (i_we) begin
      r_mem[i_waddr] <= i_wdata;
    end
  end

  assign o_rdata_a = r_mem[i_raddr_a];
  assign o_rdata_b = r_mem[i_raddr_b];

endmodule

// File: rtl/instr_feeder.sv
// -----------------------------------------------------------------------------
// instr_feeder
//   Steps through a stored program and feeds it to a simple processor one
//   instruction at a time. Each instruction is presented on Din with a
//   one-cycle Run strobe; the feeder then waits for Done before moving on.
//   mvi is followed by its immediate word, which replaces the instruction on
//   Din in the first wait cycle. The program ends on halt (FINISH), when the
//   program counter runs off the end of memory (FINISH), or when Done does
//   not arrive within TIMEOUT wait cycles (ERROR).
//
// Ports
//   clk        : clock, all state on rising edge
//   Reset      : asynchronous active-high reset (memory contents kept)
//   Start      : one-cycle request to run the program from address 0;
//                accepted in IDLE, FINISH and ERROR only
//   Done       : processor instruction complete, looked at only while waiting
//   prog_we    : program memory write enable, dropped while Busy
//   prog_addr  : program memory write address
//   prog_wdata : program memory write data
//   Run        : registered instruction-start strobe
//   Din        : registered instruction / immediate word
//   Busy       : program running
//   Finished   : sticky, program ended normally
//   Timeout    : sticky, Done missing for TIMEOUT wait cycles
//   pc         : address of the instruction currently issued
// -----------------------------------------------------------------------------
module instr_feeder
  import instr_feeder_pkg::*;
#(
  parameter int ADDR_W  = 5,
  parameter int TIMEOUT = 15
) (
  input  logic              clk,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Done,
  input  logic              prog_we,
  input  logic [ADDR_W-1:0] prog_addr,
  input  logic [WORD_W-1:0] prog_wdata,
  output logic              Run,
  output logic [WORD_W-1:0] Din,
  output logic              Busy,
  output logic              Finished,
  output logic              Timeout,
  output logic [ADDR_W-1:0] pc
);

  // Counter must be able to hold TIMEOUT-1; keep at least one bit.
  localparam int               CNT_W    = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  // ---------------------------------------------------------------------------
  // Registers and next-state values
  // ---------------------------------------------------------------------------
  state_t            r_state;
  state_t            w_state_next;
  logic              r_run;
  logic              w_run_next;
  logic [WORD_W-1:0] r_din;
  logic [WORD_W-1:0] w_din_next;
  logic              r_busy;
  logic              w_busy_next;
  logic              r_finished;
  logic              w_finished_next;
  logic              r_timeout;
  logic              w_timeout_next;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] w_pc_next;
  logic [CNT_W-1:0]  r_wcnt;
  logic [CNT_W-1:0]  w_wcnt_next;

  // ---------------------------------------------------------------------------
  // Program memory
  // ---------------------------------------------------------------------------
  logic              w_mem_we;
  logic [ADDR_W-1:0] w_pc_plus1;
  logic [WORD_W-1:0] w_word;
  logic [WORD_W-1:0] w_imm;
  opcode_t           w_op;

  // Memory cannot change under a running program, so the opcode can be
  // re-read from mem[pc] in any state instead of keeping a copy (Din holds
  // the immediate, not the opcode, while an mvi waits).
  assign w_mem_we   = prog_we & ~r_busy;
  assign w_pc_plus1 = r_pc + ADDR_W'(1);
  assign w_op       = w_word[OPC_HI:OPC_LO];

  prog_ram #(
    .ADDR_W (ADDR_W)
  ) u_prog_ram (
    .clk       (clk),
    .i_we      (w_mem_we),
    .i_waddr   (prog_addr),
    .i_wdata   (prog_wdata),
    .i_raddr_a (r_pc),
    .o_rdata_a (w_word),
    .i_raddr_b (w_pc_plus1),
    .o_rdata_b (w_imm)
  );

  // ---------------------------------------------------------------------------
  // Program-counter advance: one extra bit catches running off the end.
  // ---------------------------------------------------------------------------
  logic [1:0]      w_step;
  logic [ADDR_W:0] w_pc_sum;

  assign w_step   = is_mvi(w_op) ? 2'd2 : 2'd1;
  assign w_pc_sum = {1'b0, r_pc} + (ADDR_W + 1)'(w_step);

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next    = r_state;
    w_run_next      = 1'b0;
    w_din_next      = r_din;
    w_busy_next     = r_busy;
    w_finished_next = r_finished;
    w_timeout_next  = r_timeout;
    w_pc_next       = r_pc;
    w_wcnt_next     = r_wcnt;

    case (r_state)
      ST_IDLE, ST_FINISH, ST_ERROR: begin
        if (Start) begin
          w_state_next    = ST_LOAD;
          w_pc_next       = '0;
          w_finished_next = 1'b0;
          w_timeout_next  = 1'b0;
          w_busy_next     = 1'b1;
          w_wcnt_next     = '0;
        end
      end

      ST_LOAD: begin
        w_din_next = w_word;
        if (is_halt(w_op)) begin
          w_state_next    = ST_FINISH;
          w_finished_next = 1'b1;
          w_busy_next     = 1'b0;
        end else begin
          // Run is registered, so it is high exactly during ISSUE.
          w_state_next = ST_ISSUE;
          w_run_next   = 1'b1;
        end
      end

      ST_ISSUE: begin
        w_state_next = ST_WAIT;
        w_wcnt_next  = '0;
        // Immediate is on Din from the first wait cycle onwards.
        if (is_mvi(w_op)) begin
          w_din_next = w_imm;
        end
      end

      ST_WAIT: begin
        if (Done) begin
          w_state_next = ST_NEXT;
        end else if (r_wcnt == CNT_LAST) begin
          w_state_next   = ST_ERROR;
          w_timeout_next = 1'b1;
          w_busy_next    = 1'b0;
        end else begin
          w_wcnt_next = r_wcnt + CNT_W'(1);
        end
      end

      ST_NEXT: begin
        w_pc_next = w_pc_sum[ADDR_W-1:0];
        if (w_pc_sum[ADDR_W]) begin
          w_state_next    = ST_FINISH;
          w_finished_next = 1'b1;
          w_busy_next     = 1'b0;
        end else begin
          w_state_next = ST_LOAD;
        end
      end

      default: begin
        w_state_next = ST_IDLE;
        w_busy_next  = 1'b0;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // State register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge Reset) begin
    if (Reset) begin
      r_state    <= ST_IDLE;
      r_run      <= 1'b0;
      r_din      <= '0;
      r_busy     <= 1'b0;
      r_finished <= 1'b0;
      r_timeout  <= 1'b0;
      r_pc       <= '0;
      r_wcnt     <= '0;
    end else begin
      r_state    <= w_state_next;
      r_run      <= w_run_next;
      r_din      <= w_din_next;
      r_busy     <= w_busy_next;
      r_finished <= w_finished_next;
      r_timeout  <= w_timeout_next;
      r_pc       <= w_pc_next;
      r_wcnt     <= w_wcnt_next;
    end
  end

  assign Run      = r_run;
  assign Din      = r_din;
  assign Busy     = r_busy;
  assign Finished = r_finished;
  assign Timeout  = r_timeout;
  assign pc       = r_pc;

endmodule

// File: tb/tb_instr_feeder.sv
// -----------------------------------------------------------------------------
// tb_instr_feeder
//   Self-checking bench for instr_feeder. Programs are written into the DUT
//   and a reference model derives, from the program and the chosen Done
//   delays, which instructions must be issued, at which cycle, with which
//   immediate, and how and when the run must end.
// -----------------------------------------------------------------------------
module tb_instr_feeder;

  localparam int ADDR_W = 5;
  localparam int DEPTH  = 32;
  localparam int TMO    = 15;

  logic        clk = 1'b0;
  logic        Reset;
  logic        Start;
  logic        Done;
  logic        prog_we;
  logic [4:0]  prog_addr;
  logic [15:0] prog_wdata;
  logic        Run;
  logic [15:0] Din;
  logic        Busy;
  logic        Finished;
  logic        Timeout;
  logic [4:0]  pc;

  always #5 clk = ~clk;

  instr_feeder #(
    .ADDR_W  (ADDR_W),
    .TIMEOUT (TMO)
  ) dut (
    .clk        (clk),
    .Reset      (Reset),
    .Start      (Start),
    .Done       (Done),
    .prog_we    (prog_we),
    .prog_addr  (prog_addr),
    .prog_wdata (prog_wdata),
    .Run        (Run),
    .Din        (Din),
    .Busy       (Busy),
    .Finished   (Finished),
    .Timeout    (Timeout),
    .pc         (pc)
  );

  int errors = 0;
  int checks = 0;

  // Program image and per-instruction Done delay (wait cycle in which Done
  // is raised; 0 = never).
  logic [15:0] mem_model [DEPTH];
  int          delays    [64];
  bit          noise_en;
  bit          busy_noise_en;

  // Observations of one run (cycle 0 = cycle in which Start is high).
  int          obs_pc[$];
  logic [15:0] obs_din[$];
  logic [15:0] obs_imm[$];
  int          obs_runcyc[$];
  bit          obs_ended, obs_fin, obs_to, obs_busy_end, obs_busy_load, obs_flags_load;
  int          obs_endcyc, obs_late_runs, obs_late_busy;

  // Model expectations.
  int          exp_pc[$];
  logic [15:0] exp_din[$];
  logic [15:0] exp_imm[$];
  int          exp_runcyc[$];
  bit          exp_fin, exp_to;
  int          exp_endcyc;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic load_program();
    for (int a = 0; a < DEPTH; a++) begin
      prog_we    = 1'b1;
      prog_addr  = a[4:0];
      prog_wdata = mem_model[a];
      tick();
    end
    prog_we = 1'b0;
  endtask

  function automatic logic [15:0] rand_word(input logic [2:0] op);
    logic [15:0] w;
    w      = 16'($urandom);
    w[8:6] = op;
    return w;
  endfunction

  // Reference: walk the program by the instruction-set rules.
  task automatic model_run();
    int          p, load_cyc, run_cyc, i, k, step;
    bit          stop;
    logic [15:0] w;
    logic [2:0]  op;
    exp_pc.delete(); exp_din.delete(); exp_imm.delete(); exp_runcyc.delete();
    exp_fin = 0; exp_to = 0; exp_endcyc = 0;
    p = 0; load_cyc = 1; i = 0; stop = 0;
    while (!stop) begin
      w  = mem_model[p];
      op = w[8:6];
      if (op == 3'b111) begin
        exp_fin = 1; exp_endcyc = load_cyc + 1; stop = 1;
      end else begin
        run_cyc = load_cyc + 1;
        exp_pc.push_back(p);
        exp_din.push_back(w);
        exp_runcyc.push_back(run_cyc);
        exp_imm.push_back((op == 3'b001) ? mem_model[(p + 1) % DEPTH] : w);
        k = delays[i];
        i++;
        step = (op == 3'b001) ? 2 : 1;
        if (k < 1 || k > TMO) begin
          exp_to = 1; exp_endcyc = run_cyc + TMO + 1; stop = 1;
        end else if (p + step >= DEPTH) begin
          exp_fin = 1; exp_endcyc = run_cyc + k + 2; stop = 1;
        end else begin
          p        = p + step;
          load_cyc = run_cyc + k + 2;
        end
      end
    end
  endtask

  // Start the program, answer each Run with Done after its delay, record
  // everything seen, then watch a few cycles after the end.
  task automatic run_program(input int budget);
    int cyc, last_run, idx, cur_k, s;
    obs_pc.delete(); obs_din.delete(); obs_imm.delete(); obs_runcyc.delete();
    obs_ended = 0; obs_fin = 0; obs_to = 0; obs_busy_end = 0; obs_endcyc = -1;
    Done = 1'b0; prog_we = 1'b0;
    Start = 1'b1;
    tick();
    Start = 1'b0;
    cyc = 1; last_run = -1; idx = 0; cur_k = 0;
    obs_busy_load  = Busy;
    obs_flags_load = Finished | Timeout;
    while (!obs_ended && cyc < budget) begin
      if (last_run >= 0 && cyc == last_run + 1) obs_imm.push_back(Din);
      if (Run) begin
        obs_pc.push_back(int'(pc));
        obs_din.push_back(Din);
        obs_runcyc.push_back(cyc);
        last_run = cyc;
        cur_k    = (idx < 64) ? delays[idx] : 0;
        idx++;
      end
      if (Finished || Timeout) begin
        obs_ended = 1; obs_endcyc = cyc;
        obs_fin = Finished; obs_to = Timeout; obs_busy_end = Busy;
      end
      s       = (last_run >= 0) ? cyc - last_run : -1;
      Done    = 1'b0;
      Start   = 1'b0;
      prog_we = 1'b0;
      if (!obs_ended) begin
        if (s > 0 && cur_k != 0 && s == cur_k) begin
          Done = 1'b1;
        end else if (noise_en && (s <= 0 || (cur_k != 0 && s > cur_k))) begin
          Done = ($urandom_range(0, 1) == 1);
        end
        if (busy_noise_en && Busy) begin
          prog_we    = 1'b1;
          prog_addr  = 5'($urandom);
          prog_wdata = 16'($urandom);
          Start      = ($urandom_range(0, 3) == 0);
        end
      end
      tick();
      cyc++;
    end
    Done = 1'b0; Start = 1'b0; prog_we = 1'b0;
    checks++;
    if (!obs_ended) begin
      errors++;
      $display("FAIL run_budget: no Finished/Timeout within %0d cycles", budget);
    end
    obs_late_runs = 0; obs_late_busy = 0;
    repeat (4) begin
      tick();
      if (Run)  obs_late_runs++;
      if (Busy) obs_late_busy++;
    end
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    Reset = 1'b1; Start = 1'b0; Done = 1'b0;
    prog_we = 1'b0; prog_addr = '0; prog_wdata = '0;
    noise_en = 0; busy_noise_en = 0;
    repeat (3) tick();
    checks++; if (Run !== 1'b0)      begin errors++; $display("FAIL reset_run: got %b want 0", Run); end
    checks++; if (Din !== 16'h0)     begin errors++; $display("FAIL reset_din: got %h want 0000", Din); end
    checks++; if (Busy !== 1'b0)     begin errors++; $display("FAIL reset_busy: got %b want 0", Busy); end
    checks++; if (Finished !== 1'b0) begin errors++; $display("FAIL reset_finished: got %b want 0", Finished); end
    checks++; if (Timeout !== 1'b0)  begin errors++; $display("FAIL reset_timeout: got %b want 0", Timeout); end
    checks++; if (pc !== 5'd0)       begin errors++; $display("FAIL reset_pc: got %0d want 0", pc); end
    Reset = 1'b0;
    tick();
    $display("test_reset: done");
  endtask

  task automatic set_basic_program();
    for (int a = 0; a < DEPTH; a++) mem_model[a] = 16'h0000;
    mem_model[0] = 16'h0040;  // mvi R0
    mem_model[1] = 16'h0005;
    mem_model[2] = 16'h0048;  // mvi R1
    mem_model[3] = 16'h0003;
    mem_model[4] = 16'h0081;  // add R0,R1
    mem_model[5] = 16'h01C0;  // halt
    for (int i = 0; i < 64; i++) delays[i] = 2;
  endtask

  task automatic check_basic_trace(input string tag);
    logic [15:0] want_din [3] = '{16'h0040, 16'h0048, 16'h0081};
    logic [15:0] want_imm [2] = '{16'h0005, 16'h0003};
    int          want_cyc [3] = '{2, 7, 12};
    int          want_pc  [3] = '{0, 2, 4};
    checks++;
    if (obs_din.size() != 3) begin
      errors++;
      $display("FAIL %s_runs: got %0d Run pulses want 3", tag, obs_din.size());
    end else begin
      for (int i = 0; i < 3; i++) begin
        checks++; if (obs_din[i] !== want_din[i]) begin errors++; $display("FAIL %s_din%0d: got %h want %h", tag, i, obs_din[i], want_din[i]); end
        checks++; if (obs_runcyc[i] != want_cyc[i]) begin errors++; $display("FAIL %s_runcyc%0d: got %0d want %0d", tag, i, obs_runcyc[i], want_cyc[i]); end
        checks++; if (obs_pc[i] != want_pc[i]) begin errors++; $display("FAIL %s_pc%0d: got %0d want %0d", tag, i, obs_pc[i], want_pc[i]); end
      end
      for (int i = 0; i < 2; i++) begin
        checks++; if (obs_imm[i] !== want_imm[i]) begin errors++; $display("FAIL %s_imm%0d: got %h want %h", tag, i, obs_imm[i], want_imm[i]); end
      end
    end
    checks++; if (obs_fin !== 1'b1 || obs_to !== 1'b0) begin errors++; $display("FAIL %s_end: got fin=%b to=%b want fin=1 to=0", tag, obs_fin, obs_to); end
    checks++; if (obs_endcyc != 17) begin errors++; $display("FAIL %s_endcyc: got %0d want 17", tag, obs_endcyc); end
    checks++; if (obs_busy_end !== 1'b0 || obs_late_busy != 0) begin errors++; $display("FAIL %s_busy_end: got %b/%0d want 0/0", tag, obs_busy_end, obs_late_busy); end
  endtask

  task automatic test_basic_program();
    set_basic_program();
    noise_en = 0; busy_noise_en = 0;
    load_program();
    run_program(500);
    checks++; if (obs_busy_load !== 1'b1) begin errors++; $display("FAIL basic_busy_start: got %b want 1", obs_busy_load); end
    check_basic_trace("basic");
    $display("test_basic_program: runs=%0d end=%0d", obs_din.size(), obs_endcyc);
  endtask

  task automatic test_timeout();
    for (int a = 0; a < DEPTH; a++) mem_model[a] = rand_word(3'b000);
    for (int i = 0; i < 64; i++) delays[i] = 0;
    noise_en = 1; busy_noise_en = 0;
    load_program();
    run_program(500);
    checks++; if (obs_din.size() != 1) begin errors++; $display("FAIL timeout_runs: got %0d want 1", obs_din.size()); end
    checks++; if (obs_to !== 1'b1 || obs_fin !== 1'b0) begin errors++; $display("FAIL timeout_flags: got to=%b fin=%b want to=1 fin=0", obs_to, obs_fin); end
    // Run in cycle 2, 15 wait cycles 3..17, Timeout visible in cycle 18.
    checks++; if (obs_endcyc != 18) begin errors++; $display("FAIL timeout_cycle: got %0d want 18", obs_endcyc); end
    checks++; if (obs_busy_end !== 1'b0) begin errors++; $display("FAIL timeout_busy: got %b want 0", obs_busy_end); end
    checks++; if (obs_late_runs != 0) begin errors++; $display("FAIL timeout_late_run: got %0d want 0", obs_late_runs); end
    $display("test_timeout: end=%0d to=%b", obs_endcyc, obs_to);
  endtask

  task automatic test_full_mv();
    for (int a = 0; a < DEPTH; a++) mem_model[a] = rand_word(3'b000);
    for (int i = 0; i < 64; i++) delays[i] = $urandom_range(1, TMO);
    noise_en = 1; busy_noise_en = 0;
    load_program();
    model_run();
    run_program(2000);
    checks++;
    if (obs_pc.size() != 32) begin
      errors++; $display("FAIL fullmv_runs: got %0d want 32", obs_pc.size());
    end else begin
      for (int i = 0; i < 32; i++) begin
        checks++; if (obs_pc[i] != i) begin errors++; $display("FAIL fullmv_pc%0d: got %0d want %0d", i, obs_pc[i], i); end
        checks++; if (obs_din[i] !== mem_model[i]) begin errors++; $display("FAIL fullmv_din%0d: got %h want %h", i, obs_din[i], mem_model[i]); end
      end
    end
    checks++; if (obs_fin !== 1'b1) begin errors++; $display("FAIL fullmv_finished: got %b want 1", obs_fin); end
    checks++; if (obs_endcyc != exp_endcyc) begin errors++; $display("FAIL fullmv_endcyc: got %0d want %0d", obs_endcyc, exp_endcyc); end
    $display("test_full_mv: runs=%0d end=%0d", obs_pc.size(), obs_endcyc);
  endtask

  task automatic test_mvi_wrap();
    mem_model[0] = 16'h1234;
    for (int a = 1; a < DEPTH - 1; a++) mem_model[a] = rand_word(3'b000);
    mem_model[DEPTH-1] = rand_word(3'b001);
    for (int i = 0; i < 64; i++) delays[i] = $urandom_range(1, TMO);
    noise_en = 1; busy_noise_en = 0;
    load_program();
    model_run();
    run_program(2000);
    checks++;
    if (obs_pc.size() != 32 || obs_imm.size() != 32) begin
      errors++; $display("FAIL wrap_runs: got %0d want 32", obs_pc.size());
    end else begin
      checks++; if (obs_pc[31] != 31) begin errors++; $display("FAIL wrap_last_pc: got %0d want 31", obs_pc[31]); end
      checks++; if (obs_imm[31] !== 16'h1234) begin errors++; $display("FAIL wrap_imm: got %h want 1234", obs_imm[31]); end
    end
    checks++; if (obs_fin !== 1'b1 || obs_to !== 1'b0) begin errors++; $display("FAIL wrap_finished: got fin=%b to=%b want 1/0", obs_fin, obs_to); end
    checks++; if (obs_endcyc != exp_endcyc) begin errors++; $display("FAIL wrap_endcyc: got %0d want %0d", obs_endcyc, exp_endcyc); end
    $display("test_mvi_wrap: runs=%0d end=%0d", obs_pc.size(), obs_endcyc);
  endtask

  task automatic test_reset_mid();
    set_basic_program();
    noise_en = 0; busy_noise_en = 0;
    load_program();
    Start = 1'b1;
    tick();          // cycle 1: LOAD
    Start = 1'b0;
    tick();          // cycle 2: ISSUE
    checks++; if (Run !== 1'b1) begin errors++; $display("FAIL rstmid_run_before: got %b want 1", Run); end
    tick();          // cycle 3: first WAIT
    tick();          // cycle 4: second WAIT
    checks++; if (Busy !== 1'b1 || Din !== 16'h0005) begin errors++; $display("FAIL rstmid_wait: got busy=%b din=%h want 1/0005", Busy, Din); end
    Reset = 1'b1;
    #1;
    checks++; if (Run !== 1'b0)  begin errors++; $display("FAIL rstmid_run: got %b want 0", Run); end
    checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rstmid_busy: got %b want 0", Busy); end
    checks++; if (Din !== 16'h0) begin errors++; $display("FAIL rstmid_din: got %h want 0000", Din); end
    checks++; if (pc !== 5'd0)   begin errors++; $display("FAIL rstmid_pc: got %0d want 0", pc); end
    tick();
    Reset = 1'b0;
    tick();
    run_program(500);
    check_basic_trace("rerun");
    $display("test_reset_mid: rerun runs=%0d end=%0d", obs_din.size(), obs_endcyc);
  endtask

  task automatic test_busy_protect();
    logic [2:0] ops [6] = '{3'b000, 3'b010, 3'b011, 3'b100, 3'b101, 3'b110};
    for (int a = 0; a < DEPTH; a++) mem_model[a] = rand_word(ops[$urandom_range(0, 5)]);
    for (int i = 0; i < 64; i++) delays[i] = $urandom_range(1, TMO);
    noise_en = 0;
    load_program();
    for (int pass = 0; pass < 2; pass++) begin
      busy_noise_en = (pass == 0);
      run_program(2000);
      checks++;
      if (obs_pc.size() != 32) begin
        errors++; $display("FAIL protect%0d_runs: got %0d want 32", pass, obs_pc.size());
      end else begin
        for (int i = 0; i < 32; i++) begin
          checks++; if (obs_pc[i] != i) begin errors++; $display("FAIL protect%0d_pc%0d: got %0d want %0d", pass, i, obs_pc[i], i); end
          checks++; if (obs_din[i] !== mem_model[i]) begin errors++; $display("FAIL protect%0d_din%0d: got %h want %h", pass, i, obs_din[i], mem_model[i]); end
        end
      end
      checks++; if (obs_fin !== 1'b1) begin errors++; $display("FAIL protect%0d_finished: got %b want 1", pass, obs_fin); end
      $display("test_busy_protect: pass=%0d runs=%0d", pass, obs_pc.size());
    end
    busy_noise_en = 0;
  endtask

  task automatic test_random();
    int r;
    for (int iter = 0; iter < 8; iter++) begin
      for (int a = 0; a < DEPTH; a++) begin
        r = $urandom_range(0, 11);
        mem_model[a] = rand_word((r == 0) ? 3'b111 : 3'($urandom_range(0, 6)));
      end
      for (int i = 0; i < 64; i++) begin
        r = $urandom_range(0, 24);
        delays[i] = (r == 0) ? 0 : ((r - 1) % TMO) + 1;
      end
      noise_en = 1; busy_noise_en = 0;
      load_program();
      model_run();
      run_program(2000);
      checks++; if (obs_busy_load !== 1'b1 || obs_flags_load !== 1'b0) begin errors++; $display("FAIL rnd%0d_start: got busy=%b flags=%b want 1/0", iter, obs_busy_load, obs_flags_load); end
      checks++;
      if (obs_pc.size() != exp_pc.size() || obs_imm.size() != exp_pc.size()) begin
        errors++; $display("FAIL rnd%0d_runs: got %0d want %0d", iter, obs_pc.size(), exp_pc.size());
      end else begin
        for (int i = 0; i < exp_pc.size(); i++) begin
          checks++; if (obs_pc[i] != exp_pc[i]) begin errors++; $display("FAIL rnd%0d_pc%0d: got %0d want %0d", iter, i, obs_pc[i], exp_pc[i]); end
          checks++; if (obs_din[i] !== exp_din[i]) begin errors++; $display("FAIL rnd%0d_din%0d: got %h want %h", iter, i, obs_din[i], exp_din[i]); end
          checks++; if (obs_imm[i] !== exp_imm[i]) begin errors++; $display("FAIL rnd%0d_imm%0d: got %h want %h", iter, i, obs_imm[i], exp_imm[i]); end
          checks++; if (obs_runcyc[i] != exp_runcyc[i]) begin errors++; $display("FAIL rnd%0d_runcyc%0d: got %0d want %0d", iter, i, obs_runcyc[i], exp_runcyc[i]); end
        end
      end
      checks++; if (obs_fin !== exp_fin || obs_to !== exp_to) begin errors++; $display("FAIL rnd%0d_end: got fin=%b to=%b want fin=%b to=%b", iter, obs_fin, obs_to, exp_fin, exp_to); end
      checks++; if (obs_endcyc != exp_endcyc) begin errors++; $display("FAIL rnd%0d_endcyc: got %0d want %0d", iter, obs_endcyc, exp_endcyc); end
      checks++; if (obs_busy_end !== 1'b0 || obs_late_runs != 0) begin errors++; $display("FAIL rnd%0d_after: got busy=%b late_runs=%0d want 0/0", iter, obs_busy_end, obs_late_runs); end
      $display("test_random: iter=%0d runs=%0d fin=%b to=%b end=%0d", iter, obs_pc.size(), obs_fin, obs_to, obs_endcyc);
    end
  endtask

  initial begin
    test_reset();
    test_basic_program();
    test_timeout();
    test_full_mv();
    test_mvi_wrap();
    test_reset_mid();
    test_busy_protect();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not complete, errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
